// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared encodings for the iterative shift sequencer.
// Op codes, FSM state encoding and the shift-step width live here.
// Optional feature switch: ROTR_EN (rotate-right on op 11).
package shift_seq_pkg;

  // Operation encodings as presented on op_i
  localparam logic [1:0] SHIFT_OP_SLL  = 2'b00;
  localparam logic [1:0] SHIFT_OP_SRL  = 2'b01;
  localparam logic [1:0] SHIFT_OP_SRA  = 2'b10;
  localparam logic [1:0] SHIFT_OP_ROTR = 2'b11;

  // Width of the per-cycle shift amount; holds 0..8
  localparam int K_W = 4;

  // Sequencer states
  typedef enum logic [1:0] {
    SHIFT_ST_IDLE  = 2'd0,
    SHIFT_ST_SHIFT = 2'd1,
    SHIFT_ST_DONE  = 2'd2
  } shift_state_t;

  // True when the op needs SHIFT cycles; an unsupported op 11 just passes data through
  function automatic logic op_shifts(input logic [1:0] op);
`ifdef ROTR_EN
    op_shifts = 1'b1;
    if (op == SHIFT_OP_ROTR) op_shifts = 1'b1;
`else
    op_shifts = (op != SHIFT_OP_ROTR);
`endif
  endfunction

endpackage

// File: rtl/shift_step.sv
// shift_step: purely combinational one-step shifter used by shift_seq.
// Shifts value by k (0..8) according to op; SRA fills with the captured sign.
// With ROTR_EN defined, op 11 rotates right; otherwise op 11 passes value unchanged.
module shift_step
  import shift_seq_pkg::*;
(
  input  logic [31:0]    value,
  input  logic [1:0]     op,
  input  logic [K_W-1:0] k,
  input  logic           sign,
  output logic [31:0]    next_value
);

  logic [63:0] wide;

  // One shift step; the 64-bit window gives sign fill and rotate wrap for free
  always_comb begin
    wide       = 64'd0;
    next_value = value;
    case (op)
      SHIFT_OP_SLL: next_value = value << k;
      SHIFT_OP_SRL: next_value = value >> k;
      SHIFT_OP_SRA: begin
        wide       = {{32{sign}}, value} >> k;
        next_value = wide[31:0];
      end
      default: begin
`ifdef ROTR_EN
        wide       = {value, value} >> k;
        next_value = wide[31:0];
`else
        next_value = value;
`endif
      end
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// shift_seq: iterative SLL/SRL/SRA(/ROTR) sequencer for the EX stage.
// Shifts STEP bits per cycle, stalls the pipeline while busy and returns the
// result with a one-cycle ready strobe. Optional rotate via ROTR_EN.
module shift_seq
  import shift_seq_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        annul_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  sa_i,
  output logic [31:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  localparam logic [5:0] STEP6 = 6'(STEP);

  shift_state_t state, state_nxt;

  logic [31:0] work_reg;
  logic [31:0] result_reg;
  logic [1:0]  op_reg;
  logic [5:0]  cnt;
  logic        sign_reg;

  logic [5:0]  k6;
  logic [5:0]  cnt_nxt;
  logic [31:0] step_value;
  logic        launch;
  logic        launch_shifts;

  assign launch        = (state == SHIFT_ST_IDLE) && start_i && !annul_i;
  assign launch_shifts = (sa_i != 5'd0) && op_shifts(op_i);
  assign k6            = (cnt > STEP6) ? STEP6 : cnt;
  assign cnt_nxt       = cnt - k6;

  shift_step u_step (
    .value      (work_reg),
    .op         (op_reg),
    .k          (k6[K_W-1:0]),
    .sign       (sign_reg),
    .next_value (step_value)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SHIFT_ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; annul always returns to IDLE
  always_comb begin
    state_nxt = state;
    if (annul_i) begin
      state_nxt = SHIFT_ST_IDLE;
    end else begin
      case (state)
        SHIFT_ST_IDLE: begin
          if (start_i) state_nxt = launch_shifts ? SHIFT_ST_SHIFT : SHIFT_ST_DONE;
        end
        SHIFT_ST_SHIFT: begin
          if (cnt_nxt == 6'd0) state_nxt = SHIFT_ST_DONE;
        end
        SHIFT_ST_DONE: state_nxt = SHIFT_ST_IDLE;
        default:       state_nxt = SHIFT_ST_IDLE;
      endcase
    end
  end

  // Output decode: stall while busy or launching a real shift, ready in DONE
  always_comb begin
    ready_o    = (state == SHIFT_ST_DONE);
    stallreq_o = !rst && ((state == SHIFT_ST_SHIFT) || (launch && launch_shifts));
    result_o   = ready_o ? work_reg : result_reg;
  end

  // Operand capture at launch and one shift step per SHIFT cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_reg <= 32'd0;
      op_reg   <= 2'd0;
      cnt      <= 6'd0;
      sign_reg <= 1'b0;
    end else if (launch) begin
      work_reg <= data_i;
      op_reg   <= op_i;
      cnt      <= {1'b0, sa_i};
      sign_reg <= data_i[31];
    end else if ((state == SHIFT_ST_SHIFT) && !annul_i) begin
      work_reg <= step_value;
      cnt      <= cnt_nxt;
    end
  end

  // Keep the last delivered result so result_o holds between operations
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        result_reg <= 32'd0;
    else if (state == SHIFT_ST_DONE) result_reg <= work_reg;
  end

endmodule
